// File: rtl/chimera_cluster_pwr_ctrl.sv
// APB-programmable power sequencer for the Chimera cluster domains (isolation, clock gate, reset).
// Define CHIMERA_PWR_IRQ_EN to add the IRQ_EN/IRQ_PEND registers and the irq_o output.

package chimera_pwr_pkg;
    typedef struct packed {
        logic [31:0] paddr;
        logic [2:0]  pprot;
        logic        psel;
        logic        penable;
        logic        pwrite;
        logic [31:0] pwdata;
        logic [3:0]  pstrb;
    } apb_req_t;

    typedef struct packed {
        logic        pready;
        logic [31:0] prdata;
        logic        pslverr;
    } apb_rsp_t;
endpackage

module chimera_cluster_pwr_ctrl
    import chimera_pwr_pkg::*;
#(
    parameter int unsigned NumClusters     = 5,
    parameter int unsigned ClkSettleCycles = 4,
    parameter int unsigned ResetCycles     = 8,
    parameter int unsigned IsoTimeout      = 256
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  apb_req_t               apb_req_i,
    output apb_rsp_t               apb_rsp_o,
    output logic [NumClusters-1:0] cluster_isolate_o,
    input  logic [NumClusters-1:0] cluster_isolated_i,
    output logic [NumClusters-1:0] cluster_clk_en_o,
    output logic [NumClusters-1:0] cluster_rst_o
`ifdef CHIMERA_PWR_IRQ_EN
    ,
    output logic                   irq_o
`endif
);

    localparam int unsigned MaxSeq    = (ClkSettleCycles > ResetCycles) ? ClkSettleCycles : ResetCycles;
    localparam int unsigned MaxCycles = (MaxSeq > IsoTimeout) ? MaxSeq : IsoTimeout;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    typedef logic [CntW-1:0] cnt_t;
    typedef enum logic [2:0] {
        PwrOff, PwrClkOn, PwrRstRel, PwrDeIso, PwrActive, PwrIso, PwrClkOff
    } pwrState_t;

    localparam cnt_t SettleLast = cnt_t'(ClkSettleCycles - 1);
    localparam cnt_t ResetLast  = cnt_t'(ResetCycles - 1);
    localparam cnt_t IsoLast    = cnt_t'(IsoTimeout - 1);

    pwrState_t              state [NumClusters];
    pwrState_t              nxt   [NumClusters];
    cnt_t                   cnt   [NumClusters];
    logic [NumClusters-1:0] ctrl, err, timeoutHit, statusVec, busyVec, errClr, wrData;
    logic                   access, wrEn, mapped;
    logic [9:0]             wordIdx;
    logic [31:0]            rdData;
    logic                   unusedApb;

    function automatic pwrState_t nextState(pwrState_t s, logic req, logic ack, cnt_t c);
        pwrState_t n;
        case (s)
            PwrOff:    n = req ? PwrClkOn : PwrOff;
            PwrClkOn:  n = (c == SettleLast) ? PwrRstRel : PwrClkOn;
            PwrRstRel: n = (c == ResetLast) ? PwrDeIso : PwrRstRel;
            PwrDeIso:  n = (!ack || c == IsoLast) ? PwrActive : PwrDeIso;
            PwrActive: n = req ? PwrActive : PwrIso;
            PwrIso:    n = (ack || c == IsoLast) ? PwrClkOff : PwrIso;
            default:   n = PwrOff;
        endcase
        return n;
    endfunction

    // {isolate, clk_en, rst} for each state
    function automatic logic [2:0] decodeOut(pwrState_t s);
        case (s)
            PwrClkOn, PwrRstRel: return 3'b111;
            PwrDeIso, PwrActive: return 3'b010;
            PwrIso:              return 3'b110;
            default:             return 3'b101;
        endcase
    endfunction

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        timeoutHit = '0;
        statusVec  = '0;
        busyVec    = '0;
        for (int i = 0; i < NumClusters; i++) begin
            nxt[i]        = nextState(state[i], ctrl[i], cluster_isolated_i[i], cnt[i]);
            timeoutHit[i] = (cnt[i] == IsoLast) &&
                            ((state[i] == PwrDeIso && cluster_isolated_i[i]) ||
                             (state[i] == PwrIso && !cluster_isolated_i[i]));
            statusVec[i]  = (state[i] == PwrActive);
            busyVec[i]    = (state[i] != PwrActive) && (state[i] != PwrOff);
        end
    end

    // Outputs are decoded from the next state and registered, so they change only on clock edges.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumClusters; i++) begin
                state[i] <= PwrOff;
                cnt[i]   <= '0;
            end
            cluster_isolate_o <= '1;
            cluster_clk_en_o  <= '0;
            cluster_rst_o     <= '1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            for (int i = 0; i < NumClusters; i++) begin
                state[i] <= nxt[i];
                cnt[i]   <= (nxt[i] != state[i]) ? '0 : ((&cnt[i]) ? cnt[i] : cnt[i] + cnt_t'(1));
                {cluster_isolate_o[i], cluster_clk_en_o[i], cluster_rst_o[i]} <= decodeOut(nxt[i]);
            end
        end
    end

    assign access    = apb_req_i.psel & apb_req_i.penable;
    assign wrEn      = access & apb_req_i.pwrite;
    assign wordIdx   = apb_req_i.paddr[11:2];
    assign wrData    = apb_req_i.pwdata[NumClusters-1:0];
    assign errClr    = (wrEn && wordIdx == 10'd3) ? wrData : '0;
    assign unusedApb = ^{apb_req_i.paddr, apb_req_i.pprot, apb_req_i.pstrb, apb_req_i.pwdata};

`ifdef CHIMERA_PWR_IRQ_EN
    logic [NumClusters-1:0] irqEn, pend, pendSet;

    always_comb begin
        pendSet = '0;
        for (int i = 0; i < NumClusters; i++) begin
            pendSet[i] = timeoutHit[i] ||
                         (nxt[i] == PwrActive && state[i] != PwrActive) ||
                         (nxt[i] == PwrOff && state[i] != PwrOff);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irqEn <= '0;
            pend  <= '0;
            irq_o <= 1'b0;
        end else begin
            if (wrEn && wordIdx == 10'd4) irqEn <= wrData;
            pend  <= (pend & ~((wrEn && wordIdx == 10'd5) ? wrData : '0)) | pendSet;
            irq_o <= |(pend & irqEn);
        end
    end
`endif

    always_comb begin
        mapped = 1'b1;
        rdData = '0;
        case (wordIdx)
            10'd0:   rdData = 32'(ctrl);
            10'd1:   rdData = 32'(statusVec);
            10'd2:   rdData = 32'(busyVec);
            10'd3:   rdData = 32'(err);
`ifdef CHIMERA_PWR_IRQ_EN
            10'd4:   rdData = 32'(irqEn);
            10'd5:   rdData = 32'(pend);
`endif
            default: mapped = 1'b0;
        endcase
    end

    always_comb begin
        apb_rsp_o         = '0;
        apb_rsp_o.pready  = 1'b1;
        apb_rsp_o.pslverr = access & ~mapped;
        if (access && !apb_req_i.pwrite && mapped) apb_rsp_o.prdata = rdData;
    end

    // A timeout set in the same cycle as a W1C clear wins.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctrl <= '0;
            err  <= '0;
        end else begin
            if (wrEn && wordIdx == 10'd0) ctrl <= wrData;
            err <= (err & ~errClr) | timeoutHit;
        end
    end

endmodule
